shot_entry: RTL

//  - Turns the debounced board switches into one validated shot coordinate per fire press.
//  - Sits directly downstream of the 10-bit switch debouncer (its SWO bus).
//  - Upstream of the game controller, which it feeds through a valid/ready handshake.
//  - Captures row/col on the rising edge of the fire switch, range-checks them, offers the shot,

---
 rtl/shot_entry_pkg.sv | 22 ++
 rtl/shot_entry_rise_detect.sv | 21 ++
 rtl/shot_entry.sv | 123 ++++++++++++
 3 files changed

// File: rtl/shot_entry_pkg.sv
// Shared board constants and shot-entry FSM encoding.
// Used by shot_entry, the grid RAM and the game controller.
// Contents: GRID_SIZE/COORD_W/CNT_W constants, state encoding, state_t enum.
package shot_entry_pkg;

   localparam int GRID_SIZE = 10;
   localparam int COORD_W   = 4;
   localparam int CNT_W     = 8;

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] CHECK    = 2'd1;
   localparam logic [1:0] OFFER    = 2'd2;
   localparam logic [1:0] WAIT_REL = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE     = IDLE,
      ST_CHECK    = CHECK,
      ST_OFFER    = OFFER,
      ST_WAIT_REL = WAIT_REL
   } state_t;

endpackage

// File: rtl/shot_entry_rise_detect.sv
// Rising-edge detector with a registered previous value that resets to 1.
// Latency: rise is combinational from din against the previous cycle's din.
// Ports: clk, rst_n (async active-low), din, rise.
module rise_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic rise
);

   logic prev_q;

   // Resetting to 1 means a level held high through reset never looks like an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prev_q <= 1'b1;
      else        prev_q <= din;
   end

   assign rise = din & ~prev_q;

endmodule

// File: rtl/shot_entry.sv
// Turns debounced switches into one range-checked shot per fire press, offered valid/ready.
// Latency: fire edge at n -> CHECK at n+1 -> shot_valid at n+2; ready stalls hold the shot.
// Ports: clk, rst_n, sw_clean[9:0] {arm,fire,col,row}, shot_ready in; shot_valid/row/col,
//        err_range, err_abort, busy, shots_fired out.
module shot_entry
   import shot_entry_pkg::*;
#(
   parameter int GRID_SIZE = shot_entry_pkg::GRID_SIZE,
   parameter int COORD_W   = shot_entry_pkg::COORD_W,
   parameter int CNT_W     = shot_entry_pkg::CNT_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [9:0]         sw_clean,
   input  logic               shot_ready,
   output logic               shot_valid,
   output logic [COORD_W-1:0] shot_row,
   output logic [COORD_W-1:0] shot_col,
   output logic               err_range,
   output logic               err_abort,
   output logic               busy,
   output logic [CNT_W-1:0]   shots_fired
);

   logic [COORD_W-1:0] row_sw;
   logic [COORD_W-1:0] col_sw;
   logic               fire_sw;
   logic               arm_sw;
   logic               fire_rise;

   assign row_sw  = sw_clean[COORD_W-1:0];
   assign col_sw  = sw_clean[2*COORD_W-1:COORD_W];
   assign fire_sw = sw_clean[8];
   assign arm_sw  = sw_clean[9];

   rise_detect u_fire_rise (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (fire_sw),
      .rise  (fire_rise)
   );

   function automatic logic in_range(input logic [COORD_W-1:0] r,
                                     input logic [COORD_W-1:0] c);
      return (int'(r) < GRID_SIZE) && (int'(c) < GRID_SIZE);
   endfunction

   state_t             state_q;
   logic               shot_valid_q;
   logic [COORD_W-1:0] row_q;
   logic [COORD_W-1:0] col_q;
   logic               err_range_q;
   logic               err_abort_q;
   logic               busy_q;
   logic [CNT_W-1:0]   shots_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         shot_valid_q <= 1'b0;
         row_q        <= '0;
         col_q        <= '0;
         err_range_q  <= 1'b0;
         err_abort_q  <= 1'b0;
         busy_q       <= 1'b0;
         shots_q      <= '0;
      end else begin
         err_range_q <= 1'b0;
         err_abort_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (fire_rise && arm_sw) begin
                  row_q       <= row_sw;
                  col_q       <= col_sw;
                  // Error is registered at capture so the pulse lines up with the CHECK cycle.
                  err_range_q <= !in_range(row_sw, col_sw);
                  busy_q      <= 1'b1;
                  state_q     <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (in_range(row_q, col_q)) begin
                  shot_valid_q <= 1'b1;
                  state_q      <= ST_OFFER;
               end else begin
                  state_q      <= ST_WAIT_REL;
               end
            end
            ST_OFFER: begin
               // Handshake has priority over an arm drop in the same cycle.
               if (shot_ready) begin
                  shot_valid_q <= 1'b0;
                  shots_q      <= shots_q + {{(CNT_W-1){1'b0}}, 1'b1};
                  state_q      <= ST_WAIT_REL;
               end else if (!arm_sw) begin
                  shot_valid_q <= 1'b0;
                  err_abort_q  <= 1'b1;
                  state_q      <= ST_WAIT_REL;
               end
            end
            ST_WAIT_REL: begin
               if (!fire_sw) begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign shot_valid  = shot_valid_q;
   assign shot_row    = row_q;
   assign shot_col    = col_q;
   assign err_range   = err_range_q;
   assign err_abort   = err_abort_q;
   assign busy        = busy_q;
   assign shots_fired = shots_q;

endmodule
